cp0_reg: RTL and testbench

Coprocessor-0 register file at the consuming end of the writeback interface. It takes the CP0 write triple (`we`, `addr`, `data`) driven out of the MEM/WB register. It also takes the precise-exception and ERET commit events from the memory stage. It owns Count/Compare timing and interrupt pending state, and gives the pipeline a combinational read port for `mfc0` plus the live Status/Cause/EPC values needed for exception and ERET redirection.

---
 rtl/cp0_pkg.sv | 46 ++++
 rtl/cp0_timer.sv | 41 ++++
 rtl/cp0_reg.sv | 115 +++++++++++
 tb/tb_cp0_reg.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and the software-writable masks for Status and Cause.
package cp0_pkg;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;
   localparam logic [4:0] CP0_PRID     = 5'd15;
   localparam logic [4:0] CP0_CONFIG   = 5'd16;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   localparam int unsigned STATUS_IE    = 0;
   localparam int unsigned STATUS_EXL   = 1;
   localparam int unsigned STATUS_IM_LO = 8;
   localparam int unsigned STATUS_IM_HI = 15;
   localparam int unsigned STATUS_BEV   = 22;
   localparam int unsigned STATUS_CU0   = 28;

   localparam int unsigned CAUSE_EXC_LO = 2;
   localparam int unsigned CAUSE_EXC_HI = 6;
   localparam int unsigned CAUSE_IP_LO  = 8;
   localparam int unsigned CAUSE_IP_HI  = 15;
   localparam int unsigned CAUSE_IV     = 23;
   localparam int unsigned CAUSE_BD     = 31;

   localparam logic [31:0] STATUS_WMASK = 32'h1040_FF03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0080_0300;
   localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, and a match against
// a nonzero Compare latches the timer interrupt until Compare is rewritten.
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o
);

   logic tick;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick        <= 1'b0;
         count_o     <= '0;
         compare_o   <= '0;
         timer_int_o <= 1'b0;
      end else begin
         tick <= ~tick;

         if (count_we)
            count_o <= wdata;
         else if (tick)
            count_o <= count_o + 32'd1;

         if (compare_we)
            compare_o <= wdata;

         // A Compare write clears the latch even if a match occurs this cycle.
         if (compare_we)
            timer_int_o <= 1'b0;
         else if ((count_o == compare_o) && (compare_o != '0))
            timer_int_o <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: software writes from MEM/WB, exception/ERET commit
// updates, interrupt pending logic and a combinational mfc0 read port.
module cp0_reg
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
   parameter logic [31:0] CONFIG_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cp0_reg_we,
   input  logic [4:0]  wb_cp0_reg_write_addr,
   input  logic [31:0] wb_cp0_reg_data,
   input  logic [4:0]  raddr_i,
   output logic [31:0] rdata_o,
   input  logic [5:0]  int_i,
   input  logic        exc_valid_i,
   input  logic [4:0]  exc_code_i,
   input  logic [31:0] exc_pc_i,
   input  logic        exc_in_delayslot_i,
   input  logic [31:0] exc_badvaddr_i,
   input  logic        eret_i,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o,
   output logic        int_pending_o
);

   logic [31:0] status_q;
   logic [31:0] cause_q;
   logic [31:0] epc_q;
   logic [31:0] badvaddr_q;
   logic        count_we;
   logic        compare_we;
   logic        status_we;
   logic        cause_we;
   logic        epc_we;

   always_comb begin
      count_we   = wb_cp0_reg_we && (wb_cp0_reg_write_addr == CP0_COUNT);
      compare_we = wb_cp0_reg_we && (wb_cp0_reg_write_addr == CP0_COMPARE);
      status_we  = wb_cp0_reg_we && (wb_cp0_reg_write_addr == CP0_STATUS);
      cause_we   = wb_cp0_reg_we && (wb_cp0_reg_write_addr == CP0_CAUSE);
      epc_we     = wb_cp0_reg_we && (wb_cp0_reg_write_addr == CP0_EPC);
   end

   cp0_timer u_timer (
      .clk         (clk),
      .rst         (rst),
      .count_we    (count_we),
      .compare_we  (compare_we),
      .wdata       (wb_cp0_reg_data),
      .count_o     (count_o),
      .compare_o   (compare_o),
      .timer_int_o (timer_int_o)
   );

   // Later assignments override earlier ones: software write, then commit events.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q   <= STATUS_RESET;
         cause_q    <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
      end else begin
         if (status_we)
            status_q <= wb_cp0_reg_data & STATUS_WMASK;
         if (cause_we)
            cause_q <= (cause_q & ~CAUSE_WMASK) | (wb_cp0_reg_data & CAUSE_WMASK);
         if (epc_we)
            epc_q <= wb_cp0_reg_data;

         cause_q[CAUSE_IP_HI:CAUSE_IP_LO+2] <= {int_i[5] | timer_int_o, int_i[4:0]};

         if (exc_valid_i) begin
            status_q[STATUS_EXL]               <= 1'b1;
            cause_q[CAUSE_EXC_HI:CAUSE_EXC_LO] <= exc_code_i;
            if (!status_q[STATUS_EXL]) begin
               epc_q             <= exc_in_delayslot_i ? (exc_pc_i - 32'd4) : exc_pc_i;
               cause_q[CAUSE_BD] <= exc_in_delayslot_i;
            end
            if (is_addr_exc(exc_code_i))
               badvaddr_q <= exc_badvaddr_i;
         end else if (eret_i) begin
            status_q[STATUS_EXL] <= 1'b0;
         end
      end
   end

   assign status_o = status_q;
   assign cause_o  = cause_q;
   assign epc_o    = epc_q;

   assign int_pending_o = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                          (|(cause_q[CAUSE_IP_HI:CAUSE_IP_LO] & status_q[STATUS_IM_HI:STATUS_IM_LO]));

   always_comb begin
      rdata_o = '0;
      case (raddr_i)
         CP0_BADVADDR: rdata_o = badvaddr_q;
         CP0_COUNT:    rdata_o = count_o;
         CP0_COMPARE:  rdata_o = compare_o;
         CP0_STATUS:   rdata_o = status_q;
         CP0_CAUSE:    rdata_o = cause_q;
         CP0_EPC:      rdata_o = epc_q;
         CP0_PRID:     rdata_o = PRID_VAL;
         CP0_CONFIG:   rdata_o = CONFIG_VAL;
         default:      rdata_o = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a register-table model.
module tb_cp0_reg;

   localparam logic [31:0] PRID   = 32'h0001_8000;
   localparam logic [31:0] CONFIG = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic [5:0]  int_i;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_ds;
   logic [31:0] exc_bad;
   logic        eret;
   logic [31:0] status, cause, epc, count, compare;
   logic        timer_int, int_pending;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic        check_en = 1'b0;

   // Model: architectural registers indexed by CP0 number, plus timer state.
   logic [31:0] mreg [32];
   logic        m_tick;
   logic        m_timer;

   cp0_reg #(.PRID_VAL(PRID), .CONFIG_VAL(CONFIG)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .wb_cp0_reg_we         (we),
      .wb_cp0_reg_write_addr (waddr),
      .wb_cp0_reg_data       (wdata),
      .raddr_i               (raddr),
      .rdata_o               (rdata),
      .int_i                 (int_i),
      .exc_valid_i           (exc_valid),
      .exc_code_i            (exc_code),
      .exc_pc_i              (exc_pc),
      .exc_in_delayslot_i    (exc_ds),
      .exc_badvaddr_i        (exc_bad),
      .eret_i                (eret),
      .status_o              (status),
      .cause_o               (cause),
      .epc_o                 (epc),
      .count_o               (count),
      .compare_o             (compare),
      .timer_int_o           (timer_int),
      .int_pending_o         (int_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] wmask(input int unsigned a);
      case (a)
         9, 11, 14: return 32'hFFFF_FFFF;
         12:        return 32'h1040_FF03;
         13:        return 32'h0080_0300;
         default:   return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 5'd15) return PRID;
      if (a == 5'd16) return CONFIG;
      return mreg[a];
   endfunction

   function automatic logic m_pending();
      logic [31:0] s, c;
      s = mreg[12];
      c = mreg[13];
      return s[0] & ~s[1] & (|(c[15:8] & s[15:8]));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
      mreg[12] = 32'h0040_0000;
      m_tick   = 1'b0;
      m_timer  = 1'b0;
   endtask

   task automatic model_step();
      logic [31:0] n [32];
      logic        n_timer;
      logic [31:0] c;
      n = mreg;
      n[9] = mreg[9] + (m_tick ? 32'd1 : 32'd0);
      n_timer = m_timer | ((mreg[9] == mreg[11]) && (mreg[11] != 0));
      if (we) begin
         n[waddr] = (mreg[waddr] & ~wmask(waddr)) | (wdata & wmask(waddr));
         if (waddr == 5'd11) n_timer = 1'b0;
      end
      c = n[13];
      c[15:10] = {int_i[5] | m_timer, int_i[4:0]};
      if (exc_valid) begin
         c[6:2] = exc_code;
         n[12] = n[12] | 32'h2;
         if (!mreg[12][1]) begin
            n[14] = exc_ds ? exc_pc - 32'd4 : exc_pc;
            c[31] = exc_ds;
         end
         if (exc_code == 5'd4 || exc_code == 5'd5) n[8] = exc_bad;
      end else if (eret) begin
         n[12] = n[12] & ~32'h2;
      end
      n[13]   = c;
      mreg    = n;
      m_timer = n_timer;
      m_tick  = ~m_tick;
   endtask

   task automatic tick_clk();
      @(posedge clk);
      if (!rst) model_reset();
      else      model_step();
      #1;
   endtask

   task automatic idle();
      we = 1'b0; exc_valid = 1'b0; eret = 1'b0;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("rdata",   rdata,   mread(raddr));
         check("status",  status,  mreg[12]);
         check("cause",   cause,   mreg[13]);
         check("epc",     epc,     mreg[14]);
         check("count",   count,   mreg[9]);
         check("compare", compare, mreg[11]);
         check("timer",   {31'h0, timer_int},   {31'h0, m_timer});
         check("pending", {31'h0, int_pending}, {31'h0, m_pending()});
      end
   end

   initial begin
      logic        found;
      logic [4:0]  codes [7];
      logic [4:0]  addrs [8];
      codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

      rst = 1'b1; idle(); waddr = '0; wdata = '0; raddr = '0; int_i = '0;
      exc_code = '0; exc_pc = '0; exc_ds = 1'b0; exc_bad = '0;
      model_reset();
      #2 rst = 1'b0;
      model_reset();
      #1 check_en = 1'b1;
      repeat (2) tick_clk();
      rst = 1'b1;

      // Reset, then ten free-running clocks.
      raddr = 5'd15;
      repeat (10) tick_clk();
      check("t1_count",  count,  32'd5);
      check("t1_status", status, 32'h0040_0000);
      check("t1_timer",  {31'h0, timer_int}, 32'd0);
      check("t1_prid",   rdata,  32'h0001_8000);

      // Timer match at Compare = 3.
      we = 1'b1; waddr = 5'd9;  wdata = 32'd0; tick_clk();
      waddr = 5'd11; wdata = 32'd3; tick_clk();
      idle();
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mreg[9] == 32'd3) begin found = 1'b1; break; end
         tick_clk();
      end
      check("t2_reach3", {31'h0, found}, 32'd1);
      tick_clk();
      check("t2_timer_set", {31'h0, timer_int}, 32'd1);
      tick_clk();
      check("t2_cause15", {31'h0, cause[15]}, 32'd1);
      we = 1'b1; waddr = 5'd11; wdata = 32'd100; tick_clk(); idle();
      check("t2_timer_clr", {31'h0, timer_int}, 32'd0);

      // Interrupt pending masked by EXL, restored by ERET.
      int_i = 6'b000001;
      we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0401; tick_clk(); idle();
      check("t3_pending", {31'h0, int_pending}, 32'd1);
      exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_1000; exc_ds = 1'b0;
      tick_clk(); idle();
      check("t3_exl", {31'h0, status[1]}, 32'd1);
      check("t3_pending_exl", {31'h0, int_pending}, 32'd0);
      check("t3_epc", epc, 32'h0000_1000);
      eret = 1'b1; tick_clk(); idle();
      check("t3_pending_eret", {31'h0, int_pending}, 32'd1);

      // AdEL in a delay slot, then a nested exception.
      raddr = 5'd8;
      exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'hBFC0_0104; exc_ds = 1'b1; exc_bad = 32'h1;
      tick_clk(); idle();
      check("t4_epc",      epc,         32'hBFC0_0100);
      check("t4_bd",       {31'h0, cause[31]}, 32'd1);
      check("t4_exccode",  {27'h0, cause[6:2]}, 32'd4);
      check("t4_badvaddr", rdata,       32'h1);
      exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h1234_5678; exc_ds = 1'b0;
      tick_clk(); idle();
      check("t4_epc_hold", epc, 32'hBFC0_0100);
      check("t4_exccode2", {27'h0, cause[6:2]}, 32'd8);
      eret = 1'b1; tick_clk(); idle();

      // Status write racing an exception.
      we = 1'b1; waddr = 5'd12; wdata = 32'h0;
      exc_valid = 1'b1; exc_code = 5'd10; exc_pc = 32'h0000_2000; exc_ds = 1'b0;
      tick_clk(); idle();
      check("t5_status", status, 32'h0000_0002);
      eret = 1'b1; tick_clk(); idle();

      // Count write on a tick cycle, then wrap.
      if (!m_tick) tick_clk();
      we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_FFFF; tick_clk(); idle();
      check("t5_cnt_w",  count, 32'hFFFF_FFFF);
      tick_clk();
      check("t5_cnt_h",  count, 32'hFFFF_FFFF);
      tick_clk();
      check("t5_cnt_wrap", count, 32'h0);

      // Asynchronous reset with the timer latched.
      we = 1'b1; waddr = 5'd11; wdata = mreg[9] + 32'd3; tick_clk(); idle();
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_timer) begin found = 1'b1; break; end
         tick_clk();
      end
      check("t6_timer_up", {31'h0, timer_int}, 32'd1);
      check("t6_found", {31'h0, found}, 32'd1);
      rst = 1'b0; model_reset();
      #1;
      check("t6_status",  status,  32'h0040_0000);
      check("t6_count",   count,   32'h0);
      check("t6_compare", compare, 32'h0);
      check("t6_cause",   cause,   32'h0);
      check("t6_epc",     epc,     32'h0);
      check("t6_timer",   {31'h0, timer_int},   32'd0);
      check("t6_pending", {31'h0, int_pending}, 32'd0);
      tick_clk();
      rst = 1'b1;

      // Randomized traffic.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick_clk();
         if (!rst) begin
            rst = 1'b1;
         end else if ($urandom_range(0, 499) == 0) begin
            rst = 1'b0; model_reset();
         end
         we    = ($urandom_range(0, 2) == 0);
         waddr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
         case ($urandom_range(0, 3))
            0:       wdata = mreg[9] + 32'($urandom_range(0, 8));
            1:       wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
            default: wdata = $urandom;
         endcase
         raddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
         if ($urandom_range(0, 7) == 0) int_i = 6'($urandom);
         exc_valid = ($urandom_range(0, 11) == 0);
         eret      = ($urandom_range(0, 9) == 0);
         exc_code  = codes[$urandom_range(0, 6)];
         exc_pc    = $urandom;
         exc_ds    = 1'($urandom);
         exc_bad   = $urandom;
      end
      tick_clk();
      idle();
      repeat (3) tick_clk();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
